// File: rtl/rv_pkg.sv
// Shared RV32M definitions: funct3 opcodes, sequencer state encoding and width.
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-divide iteration on unsigned magnitudes; purely combinational.
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] quo_i,
    input  logic [W-1:0] div_i,
    output logic [W-1:0] rem_o,
    output logic [W-1:0] quo_o
);

    logic [W:0] shifted;
    logic [W:0] diff;

    // rem_i < div_i always holds, so the shifted remainder fits in W+1 bits.
    assign shifted = {rem_i, quo_i[W-1]};
    assign diff    = shifted - {1'b0, div_i};
    assign rem_o   = diff[W] ? shifted[W-1:0] : diff[W-1:0];
    assign quo_o   = {quo_i[W-2:0], ~diff[W]};

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// EX-stage RV32M sequencer: 34-cycle iterative mul/div (1 cycle for special divides).
// Holds stall high while busy; done pulses one cycle with result, ignoring the still-high start.
module ex_muldiv_ctrl
    import rv_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         flush,
    output logic         stall,
    output logic         done,
    output logic [W-1:0] result
);

    localparam int CW = $clog2(W);

    state_t          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic            sa_q, sa_d, sb_q, sb_d;
    logic [W-1:0]    b_q, b_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    result_q, result_d;

    logic            a_signed, b_signed, sa_in, sb_in;
    logic [W-1:0]    a_mag, b_mag;
    logic            div_zero, div_ovf;
    logic [W-1:0]    special_res;
    logic [W:0]      mul_sum;
    logic [2*W-1:0]  mul_next;
    logic [W-1:0]    div_rem_nxt, div_quo_nxt;
    logic [2*W-1:0]  prod_fix;
    logic [W-1:0]    quo_fix, rem_fix, fix_res;

    // Operand decode for the instruction currently offered by EX.
    assign a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    assign b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    assign sa_in    = a_signed & a[W-1];
    assign sb_in    = b_signed & b[W-1];
    assign a_mag    = sa_in ? -a : a;
    assign b_mag    = sb_in ? -b : b;

    assign div_zero = op[2] && (b == '0);
    assign div_ovf  = ((op == OP_DIV) || (op == OP_REM))
                      && (a == {1'b1, {(W-1){1'b0}}}) && (b == {W{1'b1}});
    // op[1] separates REM/REMU from DIV/DIVU; overflow DIV returns the dividend itself.
    assign special_res = div_zero ? (op[1] ? a : {W{1'b1}})
                                  : (op[1] ? {W{1'b0}} : a);

    // Shift-add: multiplier sits in the low half and drains out as the product fills in.
    assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : {(W+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[W-1:1]};

    div_step #(.W(W)) u_div_step (
        .rem_i (acc_q[2*W-1:W]),
        .quo_i (acc_q[W-1:0]),
        .div_i (b_q),
        .rem_o (div_rem_nxt),
        .quo_o (div_quo_nxt)
    );

    assign prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
    assign quo_fix  = (sa_q ^ sb_q) ? -acc_q[W-1:0] : acc_q[W-1:0];
    assign rem_fix  = sa_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
    assign fix_res  = op_q[2] ? (op_q[1] ? rem_fix : quo_fix)
                              : ((op_q == OP_MUL) ? prod_fix[W-1:0] : prod_fix[2*W-1:W]);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        stall    = 1'b0;
        done     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    stall = 1'b1;
                    op_d  = op;
                    sa_d  = sa_in;
                    sb_d  = sb_in;
                    b_d   = b_mag;
                    acc_d = {{W{1'b0}}, a_mag};
                    cnt_d = '0;
                    if (div_zero || div_ovf) begin
                        result_d = special_res;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                stall = 1'b1;
                cnt_d = cnt_q + 1'b1;
                acc_d = op_q[2] ? {div_rem_nxt, div_quo_nxt} : mul_next;
                if (cnt_q == CW'(W-1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                stall    = 1'b1;
                result_d = fix_res;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A redirect kills whatever is in flight without touching the visible result.
        if (flush) begin
            state_d  = ST_IDLE;
            done     = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed bench for ex_muldiv_ctrl: inputs driven and outputs sampled on the falling edge.
module tb_ex_muldiv_ctrl;
    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int total_cnt  = 0;
    int passed_cnt = 0;

    ex_muldiv_ctrl #(.W(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) passed_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Issues one instruction at the current falling edge and follows it to done.
    // Returns at the falling edge of the cycle after done, with start released.
    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp, input int exp_cyc);
        int   cyc;
        logic got;
        logic stall_ok;
        cyc      = 0;
        got      = 1'b0;
        stall_ok = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        start    = 1'b1;
        flush    = 1'b0;
        while (!got && cyc < 100) begin
            #1;
            if (done === 1'b1) begin
                got = 1'b1;
                chk({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
                chk({tag, "_result"}, result, exp);
                chk({tag, "_stall_in_done"}, {31'b0, stall}, 32'd0);
            end else if (stall !== 1'b1) begin
                stall_ok = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done_seen"}, {31'b0, got}, 32'd1);
        chk({tag, "_stall_while_busy"}, {31'b0, stall_ok}, 32'd1);
        start = 1'b0;
        #1;
        chk({tag, "_result_held"}, result, exp);
        chk({tag, "_done_one_cycle"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        int  dseen;
        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = OP_MUL;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_result", result, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // flush together with start in IDLE must not launch anything
        start = 1'b1; flush = 1'b1; op = OP_MUL; a = 32'd3; b = 32'd4;
        #1;
        chk("flush_start_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        chk("flush_start_idle_stall", {31'b0, stall}, 32'd0);
        chk("flush_start_idle_done", {31'b0, done}, 32'd0);
        @(negedge clk);

        do_op("mul_7_m3",      OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
        do_op("mulhu_m1_m1",   OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
        do_op("mulh_m1_m1",    OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34);
        do_op("mulhsu_m1_2",   OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34);
        do_op("div_m7_2",      OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
        do_op("rem_m7_2",      OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
        do_op("divu_100_7",    OP_DIVU,   32'd100,      32'd7,        32'd14,       34);
        do_op("remu_100_7",    OP_REMU,   32'd100,      32'd7,        32'd2,        34);
        do_op("divu_5_0",      OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1);
        do_op("rem_5_0",       OP_REM,    32'd5,        32'd0,        32'd5,        1);
        do_op("div_ovf",       OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        do_op("rem_ovf",       OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

        // flush in cycle 10 of a DIV
        op = OP_DIV; a = 32'd1000; b = 32'd3; start = 1'b1;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        #1;
        chk("flush_idle_stall", {31'b0, stall}, 32'd0);
        chk("flush_result_kept", result, 32'd0);
        dseen = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (done === 1'b1) dseen++;
        end
        chk("flush_no_done", 32'(dseen), 32'd0);
        do_op("mul_3_4_after_flush", OP_MUL, 32'd3, 32'd4, 32'd12, 34);

        // reset in cycle 20 of a MUL
        op = OP_MUL; a = 32'd9; b = 32'd9; start = 1'b1;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        #1;
        chk("rst_mid_result", result, 32'd0);
        chk("rst_mid_done", {31'b0, done}, 32'd0);
        chk("rst_mid_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);

        // back-to-back: second start rises in the cycle right after DONE
        do_op("b2b_mul_1", OP_MUL, 32'd5,      32'd6,      32'd30,        34);
        do_op("b2b_mul_2", OP_MUL, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, 34);

        $display("%0d/%0d checks passed", passed_cnt, total_cnt);
        $finish;
    end

endmodule
